// File: rtl/sram_responder.sv
// sram_responder: on-chip block-RAM stand-in for the SLC-3 external 1Mx16 SRAM.
// Define SRAM_WAIT_EN to compile in the programmable wait-state counter (WAIT_CYCLES).
module sram_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CE,
    input  logic        UB,
    input  logic        LB,
    input  logic        OE,
    input  logic        WE,
    input  logic [19:0] ADDR,
    input  logic [15:0] Data_write,
    output logic [15:0] Data_read,
    output logic        Data_oe,
    output logic        Ready,
    output logic        Busy
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, HOLD} state_t;

    state_t            state;
    logic [15:0]       mem [1<<ADDR_W];
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       data_q;
    logic              ub_q, lb_q, rd_q;
`ifdef SRAM_WAIT_EN
    logic [3:0]        cnt;
`endif

    logic              req;
    logic              done;
    logic [ADDR_W-1:0] sel_addr;
    logic [15:0]       sel_data;
    logic              sel_ub, sel_lb, sel_rd;
    logic [15:0]       mem_word;
    logic              addr_unused;

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in the range 0-15");
    end

    // Upper address bits alias onto the decoded array.
    assign addr_unused = ^ADDR[19:ADDR_W];

    assign req = ~CE & (~WE | ~OE);

    // Completion strobe plus the access attributes it applies to: the captured
    // copies when waiting, the live inputs when completing straight from IDLE.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        done     = 1'b0;
        sel_addr = addr_q;
        sel_data = data_q;
        sel_ub   = ub_q;
        sel_lb   = lb_q;
        sel_rd   = rd_q;
`ifdef SRAM_WAIT_EN
        if ((state == RD_WAIT || state == WR_WAIT) && !CE && cnt == 4'd0)
            done = 1'b1;
`else
        if (state == IDLE && req) begin
            done     = 1'b1;
            sel_addr = ADDR[ADDR_W-1:0];
            sel_data = Data_write;
            sel_ub   = UB;
            sel_lb   = LB;
            sel_rd   = WE;
        end
`endif
    end

    assign mem_word = mem[sel_addr];

    // NOTE: the array has no reset branch so it maps onto block RAM; contents survive Reset.
    always_ff @(posedge Clk) begin
        if (done && !sel_rd) begin
            if (!sel_ub) mem[sel_addr][15:8] <= sel_data[15:8];
            if (!sel_lb) mem[sel_addr][7:0]  <= sel_data[7:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            data_q    <= 16'h0000;
            ub_q      <= 1'b1;
            lb_q      <= 1'b1;
            rd_q      <= 1'b0;
            Data_read <= 16'h0000;
            Ready     <= 1'b0;
`ifdef SRAM_WAIT_EN
            cnt       <= 4'd0;
`endif
        end else begin
            Ready <= done;
            if (done && sel_rd)
                Data_read <= {sel_ub ? 8'h00 : mem_word[15:8],
                              sel_lb ? 8'h00 : mem_word[7:0]};
            case (state)
                IDLE: if (req) begin
                    addr_q <= ADDR[ADDR_W-1:0];
                    data_q <= Data_write;
                    ub_q   <= UB;
                    lb_q   <= LB;
                    rd_q   <= WE;
`ifdef SRAM_WAIT_EN
                    cnt    <= 4'(WAIT_CYCLES);
                    state  <= WE ? RD_WAIT : WR_WAIT;
`else
                    state  <= HOLD;
`endif
                end
`ifdef SRAM_WAIT_EN
                RD_WAIT, WR_WAIT: begin
                    if (CE)
                        state <= IDLE;
                    else if (cnt != 4'd0)
                        cnt <= cnt - 4'd1;
                    else
                        state <= HOLD;
                end
`endif
                // A new request must first pass through IDLE.
                HOLD: if (CE || (OE && WE)) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign Data_oe = (state == HOLD) & rd_q & ~CE & ~OE;

`ifdef SRAM_WAIT_EN
    assign Busy = (state == RD_WAIT) || (state == WR_WAIT);
`else
    assign Busy = 1'b0;
`endif
endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed scenarios plus randomized
// accesses against an array model; latency expectations follow SRAM_WAIT_EN.
`timescale 1ns/1ps
module tb_sram_responder;
    localparam int ADDR_W      = 10;
    localparam int WAIT_CYCLES = 2;
`ifdef SRAM_WAIT_EN
    localparam int LAT    = WAIT_CYCLES + 1;
    localparam int BUSY_N = WAIT_CYCLES + 1;
`else
    localparam int LAT    = 0;
    localparam int BUSY_N = 0;
`endif

    logic        Clk, Reset, CE, UB, LB, OE, WE;
    logic [19:0] ADDR;
    logic [15:0] Data_write, Data_read;
    logic        Data_oe, Ready, Busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mem_m [1<<ADDR_W];
    logic [15:0] last_rd;

    typedef struct {
        int          lat;
        int          busy;
        logic [15:0] rd;
        logic        oe;
        logic        ready_after;
        logic        oe_drop;
    } res_t;

    sram_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .Clk(Clk), .Reset(Reset), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
        .ADDR(ADDR), .Data_write(Data_write), .Data_read(Data_read),
        .Data_oe(Data_oe), .Ready(Ready), .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [15:0] mdl_read(input logic [19:0] a, input logic ub, input logic lb);
        logic [15:0] w;
        w = mem_m[a[ADDR_W-1:0]];
        return {ub ? 8'h00 : w[15:8], lb ? 8'h00 : w[7:0]};
    endfunction

    task automatic mdl_write(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
        if (!ub) mem_m[a[ADDR_W-1:0]][15:8] = d[15:8];
        if (!lb) mem_m[a[ADDR_W-1:0]][7:0]  = d[7:0];
    endtask

    // Drives one access, scrambles the inputs mid-wait, then releases the bus.
    task automatic access(input logic w, input logic [19:0] a, input logic [15:0] d,
                          input logic ub, input logic lb, output res_t r);
        r.lat = -1; r.busy = 0; r.rd = 'x; r.oe = 1'bx; r.ready_after = 1'bx; r.oe_drop = 1'bx;
        @(negedge Clk);
        CE = 1'b0; WE = ~w; OE = w; ADDR = a; Data_write = d; UB = ub; LB = lb;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if (Ready === 1'b1) begin
                r.lat = k; r.rd = Data_read; r.oe = Data_oe;
                break;
            end
            if (Busy === 1'b1) r.busy++;
            if (k == 0) begin
                ADDR = 20'($urandom); Data_write = 16'($urandom);
                UB = 1'($urandom); LB = 1'($urandom);
            end
        end
        @(negedge Clk);
        r.ready_after = Ready;
        CE = 1'b1; WE = 1'b1; OE = 1'b1;
        #1 r.oe_drop = Data_oe;
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset = 1'b1; CE = 1'b1; WE = 1'b1; OE = 1'b1; UB = 1'b1; LB = 1'b1;
        ADDR = '0; Data_write = '0;
        repeat (2) @(negedge Clk);
        n_cmp++; if (Data_read !== 16'h0000) begin n_bad++; $display("FAIL reset_data: got %h want 0000", Data_read); end
        n_cmp++; if (Ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", Ready); end
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
        n_cmp++; if (Data_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe: got %b want 0", Data_oe); end
        Reset = 1'b0;
        last_rd = 16'h0000;
    endtask

    task automatic test_init();
        res_t r;
        for (int a = 0; a < 64; a++) begin
            access(1'b1, 20'(a), 16'h0000, 1'b0, 1'b0, r);
            mdl_write(20'(a), 16'h0000, 1'b0, 1'b0);
        end
    endtask

    task automatic test_write_read();
        res_t r;
        access(1'b1, 20'h00005, 16'h1234, 1'b0, 1'b0, r);
        mdl_write(20'h00005, 16'h1234, 1'b0, 1'b0);
        n_cmp++; if (r.lat !== LAT) begin n_bad++; $display("FAIL wr_latency: got %0d want %0d", r.lat, LAT); end
        n_cmp++; if (r.busy !== BUSY_N) begin n_bad++; $display("FAIL wr_busy_cycles: got %0d want %0d", r.busy, BUSY_N); end
        n_cmp++; if (r.ready_after !== 1'b0) begin n_bad++; $display("FAIL wr_ready_width: got %b want 0", r.ready_after); end
        n_cmp++; if (r.oe !== 1'b0) begin n_bad++; $display("FAIL wr_data_oe: got %b want 0", r.oe); end
        access(1'b0, 20'h00005, 16'h0000, 1'b0, 1'b0, r);
        last_rd = 16'h1234;
        n_cmp++; if (r.rd !== 16'h1234) begin n_bad++; $display("FAIL rd_data: got %h want 1234", r.rd); end
        n_cmp++; if (r.oe !== 1'b1) begin n_bad++; $display("FAIL rd_data_oe: got %b want 1", r.oe); end
        n_cmp++; if (r.lat !== LAT) begin n_bad++; $display("FAIL rd_latency: got %0d want %0d", r.lat, LAT); end
        n_cmp++; if (r.oe_drop !== 1'b0) begin n_bad++; $display("FAIL rd_oe_drop: got %b want 0", r.oe_drop); end
    endtask

    task automatic test_byte_lanes();
        res_t r;
        access(1'b1, 20'h00005, 16'hFFAB, 1'b1, 1'b0, r);
        mdl_write(20'h00005, 16'hFFAB, 1'b1, 1'b0);
        n_cmp++; if (r.rd !== last_rd) begin n_bad++; $display("FAIL lane_wr_keeps_read: got %h want %h", r.rd, last_rd); end
        access(1'b0, 20'h00005, 16'h0000, 1'b0, 1'b0, r);
        n_cmp++; if (r.rd !== 16'h12AB) begin n_bad++; $display("FAIL lane_full_read: got %h want 12ab", r.rd); end
        access(1'b0, 20'h00005, 16'h0000, 1'b0, 1'b1, r);
        last_rd = 16'h1200;
        n_cmp++; if (r.rd !== 16'h1200) begin n_bad++; $display("FAIL lane_ub_read: got %h want 1200", r.rd); end
    endtask

`ifdef SRAM_WAIT_EN
    task automatic test_abort();
        res_t r;
        int   seen;
        seen = 0;
        @(negedge Clk);
        CE = 1'b0; WE = 1'b0; OE = 1'b1; ADDR = 20'h00010; Data_write = 16'hBEEF; UB = 1'b0; LB = 1'b0;
        @(negedge Clk);
        CE = 1'b1; WE = 1'b1;
        for (int k = 0; k < WAIT_CYCLES + 4; k++) begin
            @(negedge Clk);
            if (Ready === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_ready: got %0d pulses want 0", seen); end
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", Busy); end
        n_cmp++; if (Data_read !== last_rd) begin n_bad++; $display("FAIL abort_data_held: got %h want %h", Data_read, last_rd); end
        access(1'b0, 20'h00010, 16'h0000, 1'b0, 1'b0, r);
        last_rd = 16'h0000;
        n_cmp++; if (r.rd !== 16'h0000) begin n_bad++; $display("FAIL abort_no_write: got %h want 0000", r.rd); end
    endtask
`endif

    task automatic test_alias();
        res_t r;
        access(1'b1, 20'h00405, 16'hCAFE, 1'b0, 1'b0, r);
        mdl_write(20'h00405, 16'hCAFE, 1'b0, 1'b0);
        access(1'b0, 20'h00005, 16'h0000, 1'b0, 1'b0, r);
        last_rd = 16'hCAFE;
        n_cmp++; if (r.rd !== 16'hCAFE) begin n_bad++; $display("FAIL alias_read: got %h want cafe", r.rd); end
    endtask

    task automatic test_reset_mid_read();
        res_t r;
        @(negedge Clk);
        CE = 1'b0; WE = 1'b1; OE = 1'b0; ADDR = 20'h00005; UB = 1'b0; LB = 1'b0;
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        n_cmp++; if (Data_read !== 16'h0000) begin n_bad++; $display("FAIL midrst_data: got %h want 0000", Data_read); end
        n_cmp++; if (Ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b want 0", Ready); end
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", Busy); end
        n_cmp++; if (Data_oe !== 1'b0) begin n_bad++; $display("FAIL midrst_oe: got %b want 0", Data_oe); end
        CE = 1'b1; OE = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        access(1'b0, 20'h00005, 16'h0000, 1'b0, 1'b0, r);
        last_rd = mdl_read(20'h00005, 1'b0, 1'b0);
        n_cmp++; if (r.lat !== LAT) begin n_bad++; $display("FAIL midrst_next_lat: got %0d want %0d", r.lat, LAT); end
        n_cmp++; if (r.rd !== last_rd) begin n_bad++; $display("FAIL midrst_next_data: got %h want %h", r.rd, last_rd); end
    endtask

    task automatic test_back_to_back();
        res_t        r;
        int          lat;
        logic [15:0] exp_d;
        lat = -1;
        exp_d = mdl_read(20'h00005, 1'b0, 1'b0);
        @(negedge Clk);
        CE = 1'b0; WE = 1'b1; OE = 1'b0; ADDR = 20'h00005; UB = 1'b0; LB = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if (Ready === 1'b1) begin lat = k; break; end
        end
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL b2b_first_lat: got %0d want %0d", lat, LAT); end
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            n_cmp++;
            if (Ready !== 1'b0 || Busy !== 1'b0 || Data_oe !== 1'b1 || Data_read !== exp_d) begin
                n_bad++;
                $display("FAIL b2b_hold: got rdy=%b busy=%b oe=%b d=%h want 0 0 1 %h",
                         Ready, Busy, Data_oe, Data_read, exp_d);
            end
        end
        OE = 1'b1;
        #1;
        n_cmp++; if (Data_oe !== 1'b0) begin n_bad++; $display("FAIL b2b_oe_release: got %b want 0", Data_oe); end
        access(1'b0, 20'h00005, 16'h0000, 1'b0, 1'b1, r);
        last_rd = mdl_read(20'h00005, 1'b0, 1'b1);
        n_cmp++; if (r.lat !== LAT) begin n_bad++; $display("FAIL b2b_second_lat: got %0d want %0d", r.lat, LAT); end
        n_cmp++; if (r.rd !== last_rd) begin n_bad++; $display("FAIL b2b_second_data: got %h want %h", r.rd, last_rd); end
    endtask

    task automatic test_random();
        res_t        r;
        logic        w, ub, lb;
        logic [19:0] a;
        logic [15:0] d, exp_d;
        for (int i = 0; i < 60; i++) begin
            w  = 1'($urandom);
            ub = ($urandom_range(0, 3) == 0);
            lb = ($urandom_range(0, 3) == 0);
            a  = (20'($urandom) & 20'hFFC00) | 20'($urandom_range(0, 63));
            d  = 16'($urandom);
            access(w, a, d, ub, lb, r);
            if (w) begin
                mdl_write(a, d, ub, lb);
                exp_d = last_rd;
            end else begin
                exp_d   = mdl_read(a, ub, lb);
                last_rd = exp_d;
            end
            n_cmp++;
            if (r.lat !== LAT || r.rd !== exp_d || r.oe !== !w || r.ready_after !== 1'b0) begin
                n_bad++;
                $display("FAIL rand_%0d: w=%b a=%h got lat=%0d d=%h oe=%b rdy2=%b want lat=%0d d=%h oe=%b rdy2=0",
                         i, w, a, r.lat, r.rd, r.oe, r.ready_after, LAT, exp_d, !w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_byte_lanes();
`ifdef SRAM_WAIT_EN
        test_abort();
`endif
        test_alias();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
